// File: rtl/alu_execute_stage.sv
// Execute pipeline stage: valid/ready capture, ALU, registered writeback and NZCV flags.
// Optional performance counters are enabled with `define ALU_EXEC_PERF_CNT_EN.

module alu #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   alucontrol,
  output logic [N-1:0] result,
  output logic [3:0]   output_flags
);

  logic [N-1:0] w_b_eff;
  logic [N:0]   w_sum;
  logic         w_is_arith;

  // Subtract is a + ~b + 1, so C is the inverted borrow.
  assign w_b_eff    = alucontrol[0] ? ~b : b;
  assign w_sum      = {1'b0, a} + {1'b0, w_b_eff} + {{N{1'b0}}, alucontrol[0]};
  assign w_is_arith = (alucontrol[3:1] == 3'b000);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    result = '0;
    case (alucontrol)
      4'b0000, 4'b0001: result = w_sum[N-1:0];
      4'b0010:          result = a & b;
      4'b0011:          result = a | b;
      default:          result = '0;
    endcase
  end

  assign output_flags[3] = result[N-1];
  assign output_flags[2] = (result == '0);
  assign output_flags[1] = w_is_arith & w_sum[N];
  assign output_flags[0] = w_is_arith & ~(a[N-1] ^ w_b_eff[N-1]) & (a[N-1] ^ w_sum[N-1]);

endmodule

module alu_execute_stage #(
  parameter int N = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [3:0]   alucontrol_i,
  input  logic         setflags_i,
  input  logic [3:0]   cond_i,
  input  logic [3:0]   rd_i,
  input  logic         regwrite_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [N-1:0] result_o,
  output logic [3:0]   rd_o,
  output logic         regwrite_o,
  output logic [3:0]   flags_o,
  output logic [31:0]  perf_issued_o,
  output logic [31:0]  perf_squashed_o
);

  logic         r_valid;
  logic [N-1:0] r_result;
  logic [3:0]   r_rd;
  logic         r_regwrite;
  logic [3:0]   r_flags;

  logic         w_ready;
  logic         w_accept;
  logic         w_cond_pass;
  logic [N-1:0] w_alu_result;
  logic [3:0]   w_alu_flags;
  logic         w_n, w_z, w_c, w_v;

  alu #(N) u_alu (
    .a            (a_i),
    .b            (b_i),
    .alucontrol   (alucontrol_i),
    .result       (w_alu_result),
    .output_flags (w_alu_flags)
  );

  assign w_ready  = !r_valid || ready_i;
  assign w_accept = valid_i && w_ready;

  assign {w_n, w_z, w_c, w_v} = r_flags;

  // Evaluated on the stored flags, so a flag-setting predecessor accepted last cycle is visible.
  always_comb begin
    w_cond_pass = 1'b0;
    case (cond_i)
      4'b0000: w_cond_pass = w_z;
      4'b0001: w_cond_pass = !w_z;
      4'b0010: w_cond_pass = w_c;
      4'b0011: w_cond_pass = !w_c;
      4'b0100: w_cond_pass = w_n;
      4'b0101: w_cond_pass = !w_n;
      4'b0110: w_cond_pass = w_v;
      4'b0111: w_cond_pass = !w_v;
      4'b1000: w_cond_pass = w_c && !w_z;
      4'b1001: w_cond_pass = !w_c || w_z;
      4'b1010: w_cond_pass = (w_n == w_v);
      4'b1011: w_cond_pass = (w_n != w_v);
      4'b1100: w_cond_pass = !w_z && (w_n == w_v);
      4'b1101: w_cond_pass = w_z || (w_n != w_v);
      4'b1110: w_cond_pass = 1'b1;
      default: w_cond_pass = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid    <= 1'b0;
      r_result   <= '0;
      r_rd       <= '0;
      r_regwrite <= 1'b0;
      r_flags    <= 4'b0000;
    end else if (w_accept) begin
      r_valid    <= 1'b1;
      r_result   <= w_alu_result;
      r_rd       <= rd_i;
      r_regwrite <= regwrite_i && w_cond_pass;
      if (setflags_i && w_cond_pass) begin
        r_flags <= w_alu_flags;
      end
    end else if (ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign ready_o    = w_ready;
  assign valid_o    = r_valid;
  assign result_o   = r_result;
  assign rd_o       = r_rd;
  assign regwrite_o = r_regwrite;
  assign flags_o    = r_flags;

`ifdef ALU_EXEC_PERF_CNT_EN
  logic [31:0] r_perf_issued;
  logic [31:0] r_perf_squashed;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_issued   <= '0;
      r_perf_squashed <= '0;
    end else if (w_accept) begin
      r_perf_issued <= r_perf_issued + 32'd1;
      if (!w_cond_pass) begin
        r_perf_squashed <= r_perf_squashed + 32'd1;
      end
    end
  end

  assign perf_issued_o   = r_perf_issued;
  assign perf_squashed_o = r_perf_squashed;
`else
  assign perf_issued_o   = '0;
  assign perf_squashed_o = '0;
`endif

endmodule

// File: tb/tb_alu_execute_stage.sv
// Directed self-checking bench for alu_execute_stage: handshake, conditions, flags, backpressure, reset.
// Counter expectations follow ALU_EXEC_PERF_CNT_EN when the bench is built with it.

module tb_alu_execute_stage;

  localparam int N = 32;
`ifdef ALU_EXEC_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_AND = 4'b0010, OP_OR = 4'b0011;
  localparam logic [3:0] C_EQ = 4'b0000, C_NE = 4'b0001, C_VS = 4'b0110, C_HI = 4'b1000;
  localparam logic [3:0] C_LS = 4'b1001, C_GE = 4'b1010, C_LT = 4'b1011, C_AL = 4'b1110, C_NV = 4'b1111;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         valid_i, ready_o;
  logic [N-1:0] a_i, b_i;
  logic [3:0]   alucontrol_i, cond_i, rd_i;
  logic         setflags_i, regwrite_i;
  logic         valid_o, ready_i;
  logic [N-1:0] result_o;
  logic [3:0]   rd_o, flags_o;
  logic         regwrite_o;
  logic [31:0]  perf_issued_o, perf_squashed_o;

  int checks = 0;
  int errors = 0;

  alu_execute_stage #(.N(N)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .valid_i         (valid_i),
    .ready_o         (ready_o),
    .a_i             (a_i),
    .b_i             (b_i),
    .alucontrol_i    (alucontrol_i),
    .setflags_i      (setflags_i),
    .cond_i          (cond_i),
    .rd_i            (rd_i),
    .regwrite_i      (regwrite_i),
    .valid_o         (valid_o),
    .ready_i         (ready_i),
    .result_o        (result_o),
    .rd_o            (rd_o),
    .regwrite_o      (regwrite_o),
    .flags_o         (flags_o),
    .perf_issued_o   (perf_issued_o),
    .perf_squashed_o (perf_squashed_o)
  );

  always #5 clk_i = ~clk_i;

  // Present one instruction at the falling edge, then return 1 time unit after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [3:0] cond, input logic sf, input logic rw, input logic [3:0] rd);
    @(negedge clk_i);
    valid_i = 1'b1; alucontrol_i = op; a_i = a; b_i = b;
    cond_i = cond; setflags_i = sf; regwrite_i = rw; rd_i = rd;
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    a_i = '0; b_i = '0; alucontrol_i = '0; cond_i = '0; rd_i = '0;
    setflags_i = 1'b0; regwrite_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_o); end
    checks++; if (flags_o !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", flags_o); end
    checks++; if (result_o !== '0) begin errors++; $display("FAIL reset_result got %h exp 0", result_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready_o); end
    checks++; if ({rd_o, regwrite_o} !== 5'b0) begin errors++; $display("FAIL reset_rd_rw got %h/%b exp 0/0", rd_o, regwrite_o); end
    checks++; if (perf_issued_o !== 32'd0 || perf_squashed_o !== 32'd0) begin
      errors++; $display("FAIL reset_perf got %0d/%0d exp 0/0", perf_issued_o, perf_squashed_o); end
  endtask

  task automatic test_add;
    issue(OP_ADD, 32'h0000F0C0, 32'h00F00308, C_AL, 1'b0, 1'b1, 4'd3);
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", valid_o); end
    checks++; if (result_o !== 32'h00F0F3C8) begin errors++; $display("FAIL add_result got %h exp 00f0f3c8", result_o); end
    checks++; if (rd_o !== 4'd3 || regwrite_o !== 1'b1) begin errors++; $display("FAIL add_rd_rw got %0d/%b exp 3/1", rd_o, regwrite_o); end
    checks++; if (flags_o !== 4'b0000) begin errors++; $display("FAIL add_flags got %b exp 0000", flags_o); end
  endtask

  task automatic test_flag_forward;
    issue(OP_SUB, 32'd5, 32'd5, C_AL, 1'b1, 1'b0, 4'd1);
    checks++; if (flags_o[2] !== 1'b1 || flags_o[3] !== 1'b0) begin errors++; $display("FAIL sub_zn got Z=%b N=%b exp Z=1 N=0", flags_o[2], flags_o[3]); end
    checks++; if (flags_o !== 4'b0110) begin errors++; $display("FAIL sub_flags got %b exp 0110", flags_o); end
    issue(OP_ADD, 32'd1, 32'd1, C_EQ, 1'b0, 1'b1, 4'd2);
    checks++; if (regwrite_o !== 1'b1) begin errors++; $display("FAIL eq_regwrite got %b exp 1", regwrite_o); end
    checks++; if (result_o !== 32'd2) begin errors++; $display("FAIL eq_result got %h exp 2", result_o); end
  endtask

  task automatic test_squash;
    issue(OP_OR, 32'h0F09000F, 32'h0F0F0000, C_NE, 1'b1, 1'b1, 4'd4);
    checks++; if (result_o !== 32'h0F0F000F || valid_o !== 1'b1) begin errors++; $display("FAIL ne_result got %h/%b exp 0f0f000f/1", result_o, valid_o); end
    checks++; if (regwrite_o !== 1'b0) begin errors++; $display("FAIL ne_regwrite got %b exp 0", regwrite_o); end
    checks++; if (flags_o !== 4'b0110) begin errors++; $display("FAIL ne_flags got %b exp 0110", flags_o); end
    checks++; if (perf_issued_o !== (PERF ? 32'd4 : 32'd0) || perf_squashed_o !== (PERF ? 32'd1 : 32'd0)) begin
      errors++; $display("FAIL ne_perf got %0d/%0d exp %0d/%0d", perf_issued_o, perf_squashed_o, PERF ? 4 : 0, PERF ? 1 : 0); end
  endtask

  task automatic test_conditions;
    issue(OP_ADD, 32'h7FFFFFFF, 32'd1, C_AL, 1'b1, 1'b1, 4'd5);
    checks++; if (result_o !== 32'h80000000 || flags_o !== 4'b1001) begin errors++; $display("FAIL ovf got %h/%b exp 80000000/1001", result_o, flags_o); end
    issue(OP_ADD, 32'd0, 32'd0, C_GE, 1'b0, 1'b1, 4'd6);
    checks++; if (regwrite_o !== 1'b1) begin errors++; $display("FAIL ge_pass got %b exp 1", regwrite_o); end
    issue(OP_ADD, 32'd0, 32'd0, C_LT, 1'b1, 1'b1, 4'd6);
    checks++; if (regwrite_o !== 1'b0 || flags_o !== 4'b1001) begin errors++; $display("FAIL lt_squash got %b/%b exp 0/1001", regwrite_o, flags_o); end
    issue(OP_ADD, 32'd0, 32'd0, C_VS, 1'b0, 1'b1, 4'd6);
    checks++; if (regwrite_o !== 1'b1) begin errors++; $display("FAIL vs_pass got %b exp 1", regwrite_o); end
    issue(OP_ADD, 32'hFFFFFFFF, 32'd1, C_AL, 1'b1, 1'b1, 4'd7);
    checks++; if (result_o !== 32'd0 || flags_o !== 4'b0110) begin errors++; $display("FAIL carry got %h/%b exp 0/0110", result_o, flags_o); end
    issue(OP_ADD, 32'd0, 32'd0, C_HI, 1'b0, 1'b1, 4'd8);
    checks++; if (regwrite_o !== 1'b0) begin errors++; $display("FAIL hi_squash got %b exp 0", regwrite_o); end
    issue(OP_ADD, 32'd0, 32'd0, C_LS, 1'b0, 1'b1, 4'd8);
    checks++; if (regwrite_o !== 1'b1) begin errors++; $display("FAIL ls_pass got %b exp 1", regwrite_o); end
    issue(OP_ADD, 32'd3, 32'd4, C_NV, 1'b1, 1'b1, 4'd9);
    checks++; if (regwrite_o !== 1'b0 || valid_o !== 1'b1 || result_o !== 32'd7 || flags_o !== 4'b0110) begin
      errors++; $display("FAIL nv_squash got rw=%b v=%b r=%h f=%b exp 0/1/7/0110", regwrite_o, valid_o, result_o, flags_o); end
    checks++; if (perf_issued_o !== (PERF ? 32'd12 : 32'd0) || perf_squashed_o !== (PERF ? 32'd4 : 32'd0)) begin
      errors++; $display("FAIL cond_perf got %0d/%0d exp %0d/%0d", perf_issued_o, perf_squashed_o, PERF ? 12 : 0, PERF ? 4 : 0); end
  endtask

  task automatic test_backpressure;
    issue(OP_AND, 32'hFF00FF00, 32'h0F0F0F0F, C_AL, 1'b0, 1'b1, 4'd7);
    checks++; if (result_o !== 32'h0F000F00 || rd_o !== 4'd7) begin errors++; $display("FAIL bp_first got %h/%0d exp 0f000f00/7", result_o, rd_o); end
    @(negedge clk_i);
    ready_i = 1'b0; alucontrol_i = OP_SUB; a_i = 32'd10; b_i = 32'd3; rd_i = 4'd9;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      checks++; if (ready_o !== 1'b0 || valid_o !== 1'b1 || result_o !== 32'h0F000F00 || rd_o !== 4'd7) begin
        errors++; $display("FAIL bp_hold%0d got rdy=%b v=%b r=%h rd=%0d exp 0/1/0f000f00/7", i, ready_o, valid_o, result_o, rd_o); end
    end
    @(negedge clk_i); ready_i = 1'b1; #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready got %b exp 1", ready_o); end
    @(posedge clk_i); #1;
    checks++; if (result_o !== 32'd7 || rd_o !== 4'd9 || valid_o !== 1'b1) begin errors++; $display("FAIL bp_next got %h/%0d/%b exp 7/9/1", result_o, rd_o, valid_o); end
    @(negedge clk_i); valid_i = 1'b0;
    @(posedge clk_i); #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL drain_valid got %b exp 0", valid_o); end
    checks++; if (perf_issued_o !== (PERF ? 32'd14 : 32'd0)) begin errors++; $display("FAIL bp_perf got %0d exp %0d", perf_issued_o, PERF ? 14 : 0); end
  endtask

  task automatic test_async_reset;
    issue(OP_ADD, 32'h7FFFFFFF, 32'd1, C_AL, 1'b1, 1'b1, 4'd2);
    ready_i = 1'b0; alucontrol_i = OP_SUB; a_i = 32'd5; b_i = 32'd5; setflags_i = 1'b1;
    #2;
    checks++; if (valid_o !== 1'b1 || flags_o !== 4'b1001) begin errors++; $display("FAIL pre_rst got %b/%b exp 1/1001", valid_o, flags_o); end
    rst_ni = 1'b0; #1;
    checks++; if (valid_o !== 1'b0 || flags_o !== 4'b0000 || result_o !== '0) begin
      errors++; $display("FAIL async_rst got v=%b f=%b r=%h exp 0/0000/0", valid_o, flags_o, result_o); end
    checks++; if (perf_issued_o !== 32'd0 || perf_squashed_o !== 32'd0) begin errors++; $display("FAIL rst_perf got %0d/%0d exp 0/0", perf_issued_o, perf_squashed_o); end
    @(negedge clk_i); valid_i = 1'b0; ready_i = 1'b1; rst_ni = 1'b1;
    @(posedge clk_i); #1;
    checks++; if (valid_o !== 1'b0 || flags_o !== 4'b0000) begin errors++; $display("FAIL post_rst got %b/%b exp 0/0000", valid_o, flags_o); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_flag_forward();
    test_squash();
    test_conditions();
    test_backpressure();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
